// File: rtl/mem_responder.sv
// Memory responder: one request in flight, fixed LATENCY from accept to response.
// Define MEM_ALIGN_CHECK_EN to flag misaligned requests through resp_err.
module mem_responder #(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_AW     = 10,
    parameter int LATENCY    = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [DATA_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam logic [3:0] CNT_LOAD = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    logic [1:0]            state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  we_q, we_d;
    logic [MEM_AW-1:0]     idx_q, idx_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  mis_q, mis_d;

    logic [DATA_WIDTH-1:0] mem [2**MEM_AW];
    logic                  accept;
    logic                  mem_we;
    logic                  unused_addr;

    // Upper address bits alias; low bits only matter for the alignment check.
    assign unused_addr = ^req_addr;

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign accept     = req_valid && req_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        mis_d   = mis_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    we_d    = req_we;
                    idx_d   = req_addr[MEM_AW+1:2];
                    wdata_d = req_wdata;
`ifdef MEM_ALIGN_CHECK_EN
                    mis_d   = (req_addr[1:0] != 2'b00);
`else
                    mis_d   = 1'b0;
`endif
                    if (LATENCY == 1) begin
                        state_d = RESP;
                    end else begin
                        state_d = BUSY;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            BUSY: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            mis_q   <= mis_d;
        end
    end

    // Commit on the edge leaving RESP; a reset drops the state out of RESP first.
    assign mem_we = resp_valid && we_q && !mis_q;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[idx_q] <= wdata_q;
        end
    end

    always_comb begin
        resp_err   = resp_valid && mis_q;
        resp_rdata = '0;
        if (resp_valid && !mis_q) begin
            resp_rdata = we_q ? wdata_q : mem[idx_q];
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Randomized bench for mem_responder against a word-array reference model.
// Build with or without MEM_ALIGN_CHECK_EN; expectations follow the macro.
module tb_mem_responder;

    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;

    logic        v1, rdy1, we1, rv1, err1;
    logic [31:0] a1, wd1, rd1;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] model [int];

    always #5 clk = ~clk;

    mem_responder #(.DATA_WIDTH(32), .MEM_AW(10), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    mem_responder #(.DATA_WIDTH(32), .MEM_AW(10), .LATENCY(1)) dut1 (
        .clk(clk), .rst(rst),
        .req_valid(v1), .req_ready(rdy1), .req_we(we1),
        .req_addr(a1), .req_wdata(wd1),
        .resp_valid(rv1), .resp_rdata(rd1), .resp_err(err1)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit is_err(input logic [31:0] a);
`ifdef MEM_ALIGN_CHECK_EN
        return a[1:0] != 2'b00;
`else
        return (a[1:0] == 2'b00) && (a[1:0] != 2'b00);
`endif
    endfunction

    // Issue one request from a negedge, wait for its response and score it.
    task automatic do_req(input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, output logic [31:0] got);
        int n;
        int idx;
        idx = int'(addr[11:2]);
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        @(negedge clk);
        req_valid = 1'b0;
        req_we    = 1'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;
        n = 1;
        while (!resp_valid && n < 20) begin
            check("ready_busy", 32'(req_ready), 32'd0);
            check("rdata_idle", resp_rdata, 32'd0);
            @(negedge clk);
            n++;
        end
        check("latency", 32'(n), 32'(LAT));
        got = resp_rdata;
        if (is_err(addr)) begin
            check("err_flag", 32'(resp_err), 32'd1);
            check("err_rdata", resp_rdata, 32'd0);
        end else begin
            check("err_clear", 32'(resp_err), 32'd0);
            if (we) begin
                check("wr_echo", resp_rdata, wdata);
                model[idx] = wdata;
            end else if (model.exists(idx)) begin
                check("rd_data", resp_rdata, model[idx]);
            end
        end
        @(negedge clk);
        check("pulse_end", 32'(resp_valid), 32'd0);
        check("err_idle", 32'(resp_err), 32'd0);
    endtask

    initial begin
        logic [31:0] got;
        logic [31:0] addr;
        rst = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        v1 = 1'b0; we1 = 1'b0; a1 = '0; wd1 = '0;
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_valid", 32'(resp_valid), 32'd0);
        check("rst_rdata", resp_rdata, 32'd0);
        check("rst_err", 32'(resp_err), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        do_req(1'b1, 32'h0000_0040, 32'hDEAD_BEEF, got);
        do_req(1'b0, 32'h0000_0040, 32'h0, got);
        check("wr_rd_40", got, 32'hDEAD_BEEF);

        // Valid held high: ready only every LAT+1 cycles.
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h8; req_wdata = '0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            check("hs_ready", 32'(req_ready), 32'((k % (LAT + 1)) == 0));
            check("hs_valid", 32'(resp_valid), 32'((k % (LAT + 1)) == LAT));
        end
        req_valid = 1'b0;

        do_req(1'b1, 32'h0000_1004, 32'h1234_5678, got);
        do_req(1'b0, 32'h0000_0004, 32'h0, got);
        check("alias", got, 32'h1234_5678);

        // Reset while BUSY aborts the write.
        do_req(1'b1, 32'h10, 32'h0BAD_F00D, got);
        req_valid = 1'b1; req_we = 1'b1;
        req_addr = 32'h10; req_wdata = 32'hAAAA_5555;
        @(negedge clk);
        req_valid = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("arst_ready", 32'(req_ready), 32'd1);
        check("arst_valid", 32'(resp_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check("arst_noresp", 32'(resp_valid), 32'd0);
            @(negedge clk);
        end
        do_req(1'b0, 32'h10, 32'h0, got);
        check("arst_keep", got, 32'h0BAD_F00D);

        do_req(1'b1, 32'h20, 32'h1111_2222, got);
        do_req(1'b1, 32'h22, 32'hFFFF_FFFF, got);
        do_req(1'b0, 32'h20, 32'h0, got);
`ifdef MEM_ALIGN_CHECK_EN
        check("align_keep", got, 32'h1111_2222);
`else
        check("align_off", got, 32'hFFFF_FFFF);
`endif

        for (int i = 0; i < 150; i++) begin
            addr = ($urandom & 32'hFFFF_F000) | ((32'($urandom) % 8) << 2)
                 | (32'($urandom) % 4);
            do_req(1'($urandom), addr, $urandom, got);
            repeat ($urandom % 3) @(negedge clk);
        end

        // LATENCY = 1 instance.
        v1 = 1'b1; we1 = 1'b1; a1 = 32'h40; wd1 = 32'h5A5A_0001;
        @(negedge clk);
        v1 = 1'b0;
        check("l1_valid", 32'(rv1), 32'd1);
        check("l1_echo", rd1, 32'h5A5A_0001);
        @(negedge clk);
        check("l1_ready", 32'(rdy1), 32'd1);
        v1 = 1'b1; we1 = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            check("l1_hs_valid", 32'(rv1), 32'(k % 2));
            check("l1_hs_ready", 32'(rdy1), 32'((k % 2) == 0));
            if (k % 2 == 1) check("l1_rdata", rd1, 32'h5A5A_0001);
        end
        v1 = 1'b0;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
- REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of the data and address words.
- REQ-002 SHALL have parameter MEM_AW, default 10, log2 of the memory depth in words.
- REQ-003 SHALL have parameter LATENCY, default 3, cycles from request accept to response; legal range 1..15.
- REQ-004 SHALL have one clock and an asynchronous, active-high reset; the ports are listed in REQ-005 and REQ-006.
- REQ-005 SHALL have port clk, input, 1 bit: the single clock, rising edge.
- REQ-006 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
- REQ-007 SHALL have port req_valid, input, 1 bit: miss or write request from the cache.
- REQ-008 SHALL have port req_ready, output, 1 bit: the responder can accept a request.
- REQ-009 SHALL have port req_we, input, 1 bit: 1 = write, 0 = read (refill).
- REQ-010 SHALL have port req_addr, input, DATA_WIDTH bits: byte address.
- REQ-011 SHALL have port req_wdata, input, DATA_WIDTH bits: write data.
- REQ-012 SHALL have port resp_valid, output, 1 bit: single-cycle response pulse.
- REQ-013 SHALL have port resp_rdata, output, DATA_WIDTH bits: refill data, valid when resp_valid = 1.
- REQ-014 SHALL have port resp_err, output, 1 bit: misaligned-request flag, valid when resp_valid = 1.

Function
- REQ-015 SHALL implement a three-state FSM: IDLE, BUSY, RESP.
- REQ-016 SHALL drive req_ready = 1 only in IDLE.
- REQ-017 SHALL accept a request on a rising edge where req_valid && req_ready, latching req_we, req_addr and req_wdata.
- REQ-018 SHALL assert resp_valid for exactly one cycle, LATENCY cycles after the accepting edge.
  - LATENCY = 1: IDLE -> RESP directly.
  - Otherwise: IDLE -> BUSY, with a down-counter loaded with LATENCY-2; BUSY -> RESP when the counter = 0.
- REQ-019 SHALL transition RESP -> IDLE unconditionally, giving a maximum throughput of one request per LATENCY+1 cycles.
- REQ-020 SHALL ignore req_valid, req_addr, req_we and req_wdata while in BUSY or RESP; inputs SHALL be sampled only at accept.
- REQ-021 SHALL index the word array with latched addr[MEM_AW+1:2]; address bits above MEM_AW+1 SHALL be ignored, so addresses alias modulo 2^MEM_AW words.
- REQ-022 SHALL, for a read, drive resp_rdata in RESP = memory word at the index.
- REQ-023 SHALL, for a write, update the memory on the edge leaving RESP and drive resp_rdata in RESP = latched wdata (echo acknowledge).
- REQ-024 SHALL drive resp_rdata = 0 and resp_err = 0 whenever resp_valid = 0.
- REQ-025 SHALL, for a read following a write to the same index, return the new data.

Reset
- REQ-026 SHALL, when rst = 1, force IDLE immediately, clearing the counter and latched request; outputs SHALL be req_ready = 1, resp_valid = 0, resp_rdata = 0, resp_err = 0.
- REQ-027 SHALL, on reset asserted in BUSY or RESP, abort the in-flight request: no response and no memory write.
- REQ-028 SHALL NOT reset memory contents.

Configuration
- REQ-029 SHALL, with macro MEM_ALIGN_CHECK_EN defined, treat a request whose latched addr[1:0] != 0 as an error.
  - It SHALL keep normal timing, with resp_valid = 1, resp_err = 1 and resp_rdata = 0.
  - A write SHALL NOT update memory.
- REQ-030 SHALL, without MEM_ALIGN_CHECK_EN, tie resp_err to 0, ignore addr[1:0], and keep the resp_err port present.

Verification
- REQ-031 SHALL cover default-parameter write then read:
  - Write 0x0000_0040 <- 0xDEAD_BEEF accepted at edge 0 -> resp_valid at cycle 3 with rdata 0xDEAD_BEEF.
  - Read 0x0000_0040 -> rdata 0xDEAD_BEEF, resp_err 0.
- REQ-032 SHALL cover handshake: req_valid held high for 10 cycles with a read of 0x8 -> req_ready low for cycles 1..3, exactly one response, next accept at cycle 4.
- REQ-033 SHALL cover aliasing with MEM_AW = 10: write 0x0000_1004 <- 0x1234_5678, read 0x0000_0004 -> 0x1234_5678.
- REQ-034 SHALL cover reset mid-operation: write 0x10 <- 0xAAAA_5555 accepted, rst pulsed in BUSY -> no resp_valid, req_ready = 1 asynchronously, later read of 0x10 returns the prior contents.
- REQ-035 SHALL cover the alignment check with MEM_ALIGN_CHECK_EN: write 0x22 <- 0xFFFF_FFFF -> resp_err = 1, rdata 0; read 0x20 unchanged. Without the macro: resp_err = 0.
- REQ-036 SHALL cover LATENCY = 1: a read accepted at edge 0 -> resp_valid in cycle 1, back-to-back accepts every 2 cycles.
